// File: rtl/compfull_serial_if.sv
// Handshake and operand/result bundle for the bit-serial comparator.
interface compfull_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             a_gt_b;

    modport master (
        output start, a, b,
        input  busy, done, a_eq_b, a_lt_b, a_gt_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_eq_b, a_lt_b, a_gt_b
    );
endinterface

// File: rtl/compfull_serial.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake.
// Define CMP_SIGNED_EN to treat operands as two's complement.
module compfull_serial #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    compfull_serial_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;
    logic               gt_q, gt_d;
    logic               bit_a;
    logic               bit_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        bit_a   = a_q[idx_q];
        bit_b   = b_q[idx_q];

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new request too, giving gap-free back-to-back use
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = CNT_W'(WIDTH - 1);
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bit_a != bit_b) begin
`ifdef CMP_SIGNED_EN
                    // A set sign bit means the operand is the smaller one
                    if (idx_q == CNT_W'(WIDTH - 1)) begin
                        gt_d = bit_b;
                        lt_d = bit_a;
                    end else begin
                        gt_d = bit_a;
                        lt_d = bit_b;
                    end
`else
                    gt_d = bit_a;
                    lt_d = bit_b;
`endif
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.a_eq_b = eq_q;
    assign bus.a_lt_b = lt_q;
    assign bus.a_gt_b = gt_q;
endmodule

// File: tb/tb_compfull_serial.sv
// Self-checking bench for compfull_serial: directed scenarios plus random traffic
// compared every cycle against a latency/result model built from integer comparison.
module tb_compfull_serial;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    compfull_serial_if #(.WIDTH(WIDTH)) ifc ();

    compfull_serial #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result encoding {eq, lt, gt}
    function automatic logic [2:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        longint sx, sy;
`ifdef CMP_SIGNED_EN
        sx = longint'($signed(x));
        sy = longint'($signed(y));
`else
        sx = longint'(x);
        sy = longint'(y);
`endif
        if (sx == sy) return 3'b100;
        if (sx < sy)  return 3'b010;
        return 3'b001;
    endfunction

    function automatic int model_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        for (int i = WIDTH - 1; i >= 0; i--)
            if (x[i] != y[i]) return WIDTH - i;
        return WIDTH;
    endfunction

    // Cycle-level expectations: after acceptance busy lasts k cycles, then done with the result
    bit       mvalid = 1'b0;
    bit       m_busy, m_done;
    logic [2:0] m_flags, m_res;
    int       m_rem;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_flags = 3'b000; m_rem = 0; mvalid = 1'b1;
        end else if (mvalid) begin
            if (ifc.start && !m_busy) begin
                m_res   = model_res(ifc.a, ifc.b);
                m_rem   = model_k(ifc.a, ifc.b);
                m_busy  = 1'b1;
                m_done  = 1'b0;
                m_flags = 3'b000;
            end else if (m_busy) begin
                m_rem--;
                m_done = 1'b0;
                if (m_rem == 0) begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_flags = m_res;
                end
            end else begin
                m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_busy",  ifc.busy, m_busy);
            chk("model_done",  ifc.done, m_done);
            chk("model_flags", {ifc.a_eq_b, ifc.a_lt_b, ifc.a_gt_b}, m_flags);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmp(input string nm, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                           input int exp_k, input logic [2:0] exp_f, input int inj);
        int  busy_cnt;
        bit  seen;
        ifc.start = 1'b1; ifc.a = xa; ifc.b = xb;
        tick();
        ifc.start = 1'b0; ifc.a = 8'($urandom); ifc.b = 8'($urandom);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int n = 0; n <= WIDTH + 4 && !seen; n++) begin
            if (n > 0) begin
                tick();
                ifc.start = 1'b0;
            end
            if (n == inj) begin
                ifc.start = 1'b1; ifc.a = 8'hFF; ifc.b = 8'h00;
            end
            if (ifc.busy) busy_cnt++;
            if (ifc.done) begin
                seen = 1'b1;
                chk({nm, "_latency"}, n, exp_k);
                chk({nm, "_flags"}, {ifc.a_eq_b, ifc.a_lt_b, ifc.a_gt_b}, exp_f);
                chk({nm, "_busy_cycles"}, busy_cnt, exp_k);
            end
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
    endtask

    logic [2:0] f_msb, f_b2b1;

    initial begin
        tests = 0;
        fails = 0;
`ifdef CMP_SIGNED_EN
        f_msb  = 3'b010;
        f_b2b1 = 3'b010;
`else
        f_msb  = 3'b001;
        f_b2b1 = 3'b001;
`endif
        // Pin the model with hand-derived values
        chk("pin_k_msb", model_k(8'h80, 8'h7F), 1);
        chk("pin_k_lsb", model_k(8'h12, 8'h13), 8);
        chk("pin_k_eq",  model_k(8'h5A, 8'h5A), 8);
        chk("pin_k_b2",  model_k(8'h21, 8'h25), 6);
        chk("pin_res_eq",  model_res(8'h5A, 8'h5A), 3'b100);
        chk("pin_res_lt",  model_res(8'h12, 8'h13), 3'b010);
        chk("pin_res_msb", model_res(8'h80, 8'h7F), f_msb);

        // Reset with start asserted
        rst = 1'b1; ifc.start = 1'b1; ifc.a = 8'h55; ifc.b = 8'h33;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_busy", ifc.busy, 0);
            chk("rst_done", ifc.done, 0);
            chk("rst_flags", {ifc.a_eq_b, ifc.a_lt_b, ifc.a_gt_b}, 3'b000);
        end
        rst = 1'b0; ifc.start = 1'b0;
        tick();

        run_cmp("msb", 8'h80, 8'h7F, 1, f_msb, -1);
        tick();
        run_cmp("equal", 8'h5A, 8'h5A, 8, 3'b100, -1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("equal_hold", {ifc.a_eq_b, ifc.a_lt_b, ifc.a_gt_b}, 3'b100);
        end
        run_cmp("lsb", 8'h12, 8'h13, 8, 3'b010, 3);
        tick();

        // Abort in flight
        ifc.start = 1'b1; ifc.a = 8'h00; ifc.b = 8'h00;
        tick();
        ifc.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", ifc.busy, 0);
        chk("abort_done", ifc.done, 0);
        chk("abort_flags", {ifc.a_eq_b, ifc.a_lt_b, ifc.a_gt_b}, 3'b000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_done", ifc.done, 0);
        end
        run_cmp("after_abort", 8'h01, 8'h00, 8, 3'b001, -1);
        tick();

        // Back-to-back with start held
        ifc.start = 1'b1; ifc.a = 8'hC0; ifc.b = 8'h40;
        tick();
        ifc.a = 8'h21; ifc.b = 8'h25;
        chk("b2b_busy0", ifc.busy, 1);
        tick();
        chk("b2b_done1", ifc.done, 1);
        chk("b2b_flags1", {ifc.a_eq_b, ifc.a_lt_b, ifc.a_gt_b}, f_b2b1);
        tick();
        ifc.start = 1'b0;
        chk("b2b_accept_busy", ifc.busy, 1);
        chk("b2b_accept_done", ifc.done, 0);
        chk("b2b_accept_flags", {ifc.a_eq_b, ifc.a_lt_b, ifc.a_gt_b}, 3'b000);
        begin
            bit seen2;
            seen2 = 1'b0;
            for (int n = 1; n <= 12 && !seen2; n++) begin
                tick();
                if (ifc.done) begin
                    seen2 = 1'b1;
                    chk("b2b_latency2", n, 6);
                    chk("b2b_flags2", {ifc.a_eq_b, ifc.a_lt_b, ifc.a_gt_b}, 3'b010);
                end
            end
            if (!seen2) chk("b2b_timeout", 0, 1);
        end

        // Random traffic, checked each cycle by the model
        for (int i = 0; i < 1500; i++) begin
            logic [WIDTH-1:0] ra;
            int mode;
            tick();
            ra   = 8'($urandom);
            mode = int'($urandom_range(0, 3));
            ifc.a = ra;
            case (mode)
                0:       ifc.b = ra;
                1:       ifc.b = ra ^ (8'h01 << $urandom_range(0, WIDTH - 1));
                default: ifc.b = 8'($urandom);
            endcase
            ifc.start = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 79) == 0);
        end
        rst = 1'b0; ifc.start = 1'b0;
        repeat (WIDTH + 4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
